piso_tx: RTL and testbench

//  Parallel-in/serial-out transmitter: the sending end of the serial shift-register link.

---
 rtl/piso_tx.sv | 132 +++++++++++++
 tb/tb_piso_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter.
// Takes a WIDTH-bit word on a valid/ready handshake and shifts it out on sout,
// one bit per clk, flagging every bit with sout_valid and the final bit of the
// word with sout_last. A new word offered during the last-bit cycle is loaded
// on the same edge, so consecutive words leave with no idle gap.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] SREG_ZERO = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   sreg_r;
    logic [WIDTH-1:0]   sreg_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               in_shift_s;
    logic               cnt_zero_s;

    // Advance the shift register one position toward the output end, zero-filling.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Bit currently presented at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        logic b;
        if (MSB_FIRST) begin
            b = v[WIDTH-1];
        end else begin
            b = v[0];
        end
        return b;
    endfunction

    // Decode of the registered state shared by the handshake and the outputs.
    always_comb begin
        in_shift_s = (state_r == SHIFT);
        cnt_zero_s = (cnt_r == CNT_ZERO);
    end

    // Next-state logic: load on accept, shift mid-word, reload or drop to IDLE on the last bit.
    always_comb begin
        state_s = state_r;
        sreg_s  = sreg_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (din_valid) begin
                    state_s = SHIFT;
                    sreg_s  = din;
                    cnt_s   = CNT_MAX;
                end else begin
                    state_s = IDLE;
                    sreg_s  = sreg_r;
                    cnt_s   = cnt_r;
                end
            end
            SHIFT: begin
                if (!cnt_zero_s) begin
                    state_s = SHIFT;
                    sreg_s  = shift_toward_out(sreg_r);
                    cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (din_valid) begin
                    // Last bit is on the line and a word is waiting: reload without a gap.
                    state_s = SHIFT;
                    sreg_s  = din;
                    cnt_s   = CNT_MAX;
                end else begin
                    state_s = IDLE;
                    sreg_s  = SREG_ZERO;
                    cnt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_s = IDLE;
                sreg_s  = SREG_ZERO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State registers; reset aborts any word in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sreg_r  <= SREG_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            sreg_r  <= sreg_s;
            cnt_r   <= cnt_s;
        end
    end

    // Outputs depend on the registers only; din and din_valid never reach them.
    always_comb begin
        din_ready  = (!in_shift_s) | (in_shift_s & cnt_zero_s);
        sout_valid = in_shift_s;
        busy       = in_shift_s;
        sout_last  = in_shift_s & cnt_zero_s;
        sout       = in_shift_s & out_bit(sreg_r);
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: two instances (MSB-first and LSB-first),
// a scoreboard of expected serial bits, and a serial-in loopback register model.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din0 = 4'd0, din1 = 4'd0;
    logic       dv0 = 1'b0, dv1 = 1'b0;
    logic       rdy0, so0, sv0, sl0, busy0;
    logic       rdy1, so1, sv1, sl1, busy1;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [3:0] wq0[$];
    int         run0 = 0;
    int         max_run0 = 0;
    bit         mid0 = 1'b0;

    logic [3:0] lb_q;
    logic       lb_chk;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .sout(so0), .sout_valid(sv0), .sout_last(sl0), .busy(busy0)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .sout(so1), .sout_valid(sv1), .sout_last(sl1), .busy(busy1)
    );

    // Downstream serial-in shift register on the same clock, fed from dut0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_q   <= 4'd0;
            lb_chk <= 1'b0;
        end else begin
            lb_q   <= {lb_q[2:0], so0};
            lb_chk <= sl0;
        end
    end

    // Per-cycle output checker, sampling on the falling edge.
    task automatic monitor();
        logic [1:0] e;
        logic [3:0] w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                vectors++;
                if (busy0 !== sv0) begin
                    miscompares++;
                    $display("FAIL busy_eq_valid: busy=%b sout_valid=%b", busy0, sv0);
                end
                vectors++;
                if (rdy0 !== (!sv0 || sl0)) begin
                    miscompares++;
                    $display("FAIL din_ready: got %b want %b", rdy0, (!sv0 || sl0));
                end
                if (sv0) begin
                    run0++;
                    if (run0 > max_run0) max_run0 = run0;
                    vectors++;
                    if (q0.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_bit0: sout=%b sout_last=%b, none expected", so0, sl0);
                    end else begin
                        e = q0.pop_front();
                        if ({sl0, so0} !== e) begin
                            miscompares++;
                            $display("FAIL bit0: got last/sout=%b want %b", {sl0, so0}, e);
                        end
                        mid0 = !e[1];
                    end
                end else begin
                    run0 = 0;
                    vectors++;
                    if (so0 !== 1'b0 || sl0 !== 1'b0 || mid0) begin
                        miscompares++;
                        $display("FAIL idle0: sout=%b sout_last=%b gap_in_word=%b", so0, sl0, mid0);
                        mid0 = 1'b0;
                    end
                end
                if (lb_chk) begin
                    vectors++;
                    if (wq0.size() == 0) begin
                        miscompares++;
                        $display("FAIL loopback: q=%b with no word expected", lb_q);
                    end else begin
                        w = wq0.pop_front();
                        if (lb_q !== w) begin
                            miscompares++;
                            $display("FAIL loopback: got %b want %b", lb_q, w);
                        end
                    end
                end
                vectors++;
                if (sv1) begin
                    if (q1.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_bit1: sout=%b, none expected", so1);
                    end else begin
                        e = q1.pop_front();
                        if ({sl1, so1} !== e) begin
                            miscompares++;
                            $display("FAIL bit1: got last/sout=%b want %b", {sl1, so1}, e);
                        end
                    end
                end else if (so1 !== 1'b0 || sl1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL idle1: sout=%b last=%b busy=%b ready=%b", so1, sl1, busy1, rdy1);
                end
            end
        end
    endtask

    // Offer a word (called at posedge+1); waits for din_ready, pushes expected bits.
    task automatic send(input bit which, input logic [3:0] w, input bit hold);
        int n = 0;
        while (!(which ? rdy1 : rdy0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: din_ready=0 after %0d cycles, want 1", n);
        end
        if (which) begin
            din1 = w; dv1 = 1'b1;
            for (int i = 0; i < 4; i++) q1.push_back({(i == 3), w[i]});
        end else begin
            din0 = w; dv0 = 1'b1;
            for (int i = 0; i < 4; i++) q0.push_back({(i == 3), w[3-i]});
            wq0.push_back(w);
        end
        @(posedge clk); #1;
        if (!hold) begin
            dv0 = 1'b0;
            dv1 = 1'b0;
        end
    endtask

    // Wait until every expected bit has appeared and both instances are idle.
    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || sv0 || q1.size() != 0 || sv1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: q0=%0d q1=%0d bits pending, want 0", q0.size(), q1.size());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({so0, sv0, sl0, busy0, rdy0} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00001", {so0, sv0, sl0, busy0, rdy0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        send(1'b0, 4'b1011, 1'b0);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        max_run0 = 0;
        send(1'b0, 4'b1100, 1'b1);
        send(1'b0, 4'b0011, 1'b0);
        wait_idle();
        vectors++;
        if (max_run0 !== 8) begin
            miscompares++;
            $display("FAIL b2b_run: got %0d contiguous valid bits want 8", max_run0);
        end
    endtask

    task automatic test_lsb_first();
        send(1'b1, 4'b1011, 1'b0);
        wait_idle();
    endtask

    task automatic test_busy_ignore();
        send(1'b0, 4'b1010, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (rdy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ready: got %b want 0", rdy0);
        end
        din0 = 4'b0110; dv0 = 1'b1;
        @(posedge clk); #1;
        dv0 = 1'b0;
        wait_idle();
        send(1'b0, 4'b0101, 1'b0);
        wait_idle();
    endtask

    task automatic test_reset_mid_word();
        send(1'b0, 4'b1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({so0, sv0, sl0, busy0, rdy0} !== 5'b00001) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 00001", {so0, sv0, sl0, busy0, rdy0});
        end
        q0.delete();
        wq0.delete();
        mid0 = 1'b0;
        run0 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(1'b0, 4'b1001, 1'b0);
        wait_idle();
    endtask

    task automatic test_loopback();
        logic [3:0] w;
        bit         h;
        for (int k = 0; k < 100; k++) begin
            w = 4'($urandom_range(0, 15));
            h = 1'($urandom_range(0, 1));
            send(1'b0, w, h);
        end
        dv0 = 1'b0;
        wait_idle();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_busy_ignore();
        test_reset_mid_word();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
